// File: rtl/spi_tx_pkg.sv
// Shared types and defaults for the SPI transmit master and its FIFO.
package spi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } spi_state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_SCLK_DIV   = 4;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_GAP_CYCLES = 2;

    // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_tx_master_if.sv
// Word-push / status / SPI pin bundle between the APB wrapper side (master) and the transmitter (slave).
interface spi_tx_master_if #(
    parameter int DATA_W     = spi_tx_pkg::DEF_DATA_W,
    parameter int FIFO_DEPTH = spi_tx_pkg::DEF_FIFO_DEPTH
);
    localparam int CNT_W = spi_tx_pkg::cnt_w(FIFO_DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              clr_flags;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              busy;
    logic              overflow;
    logic              underflow;
    logic              MOSI;
    logic              CS_b;
    logic              sclk;

    modport master (
        output wr_en, wr_data, clr_flags,
        input  fifo_count, fifo_full, fifo_empty, busy, overflow, underflow, MOSI, CS_b, sclk
    );

    modport slave (
        input  wr_en, wr_data, clr_flags,
        output fifo_count, fifo_full, fifo_empty, busy, overflow, underflow, MOSI, CS_b, sclk
    );

endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous word FIFO; a push on a full FIFO succeeds only when a pop happens in the same cycle.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                     PCLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = mem[rp];

    always_ff @(posedge PCLK) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_master.sv
// SPI mode-0 MSB-first transmitter fed from spi_tx_fifo, one word per CS_b assertion.
// Optional SPI_TX_CONT_EN: re-send the last word when the FIFO runs dry and flag underflow.
module spi_tx_master
    import spi_tx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SCLK_DIV   = DEF_SCLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic           PCLK,
    input  logic           reset,
    spi_tx_master_if.slave bus
);
    localparam int               CNT_W    = cnt_w(FIFO_DEPTH);
    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [7:0]       PH_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_e        state;
    logic [7:0]        phase;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              pop;
    logic              ph_done;
    logic              gap_done;
    logic              last_bit;
    logic              cs_b_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              busy_q;
    logic              ovf_q;

    assign pop      = (state == IDLE) && !fifo_empty;
    assign ph_done  = (phase == PH_LAST);
    assign gap_done = (phase == GAP_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    spi_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .PCLK   (PCLK),
        .reset  (reset),
        .push   (bus.wr_en),
        .din    (bus.wr_data),
        .pop    (pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

`ifdef SPI_TX_CONT_EN
    logic [DATA_W-1:0] last_q;
    logic              udf_q;

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            udf_q  <= 1'b0;
        end else begin
            if (pop) last_q <= fifo_dout;
            if ((state == GAP) && gap_done && fifo_empty) udf_q <= 1'b1;
            else if (bus.clr_flags)                        udf_q <= 1'b0;
        end
    end

    assign bus.underflow = udf_q;
`else
    assign bus.underflow = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            sh_q    <= '0;
            cs_b_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            phase <= phase + 8'd1;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (!fifo_empty) begin
                        state   <= SETUP;
                        bit_cnt <= '0;
                        sh_q    <= fifo_dout;
                        mosi_q  <= fifo_dout[DATA_W-1];
                        cs_b_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (ph_done) begin
                        state  <= SHIFT_HI;
                        phase  <= '0;
                        sclk_q <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    // Final bit is held through its low phase as the slave hold time
                    if (ph_done) begin
                        state  <= SHIFT_LO;
                        phase  <= '0;
                        sclk_q <= 1'b0;
                        if (!last_bit) begin
                            sh_q   <= sh_q << 1;
                            mosi_q <= sh_q[DATA_W-2];
                        end
                    end
                end
                SHIFT_LO: begin
                    if (ph_done) begin
                        phase   <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state  <= GAP;
                            cs_b_q <= 1'b1;
                            mosi_q <= 1'b0;
                        end else begin
                            state  <= SHIFT_HI;
                            sclk_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        phase <= '0;
`ifdef SPI_TX_CONT_EN
                        if (fifo_empty) begin
                            state   <= SETUP;
                            bit_cnt <= '0;
                            sh_q    <= last_q;
                            mosi_q  <= last_q[DATA_W-1];
                            cs_b_q  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
`else
                        state  <= IDLE;
                        busy_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    phase  <= '0;
                    cs_b_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset)              ovf_q <= 1'b0;
        else if (fifo_drop)     ovf_q <= 1'b1;
        else if (bus.clr_flags) ovf_q <= 1'b0;
    end

    assign bus.fifo_count = fifo_count;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
    assign bus.MOSI       = mosi_q;
    assign bus.CS_b       = cs_b_q;
    assign bus.sclk       = sclk_q;

endmodule
